// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS frame aligner.
//   LVDS_WORD_W  : width of one captured word
//   LVDS_OFF_W   : width of a bit offset within a word
//   lvds_state_e : alignment FSM states
package lvds_pkg;

  localparam int unsigned LVDS_WORD_W = 16;
  localparam int unsigned LVDS_OFF_W  = $clog2(LVDS_WORD_W);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } lvds_state_e;

endpackage

// File: rtl/lvds_sync_search.sv
// Combinational sync-word search over every bit offset of a two-word window.
//   window     : {current word without its MSB, previous word}
//   sync_word  : pattern to look for
//   match_vec  : bit k set when window[k+W-1:k] equals sync_word
//   any_match  : at least one offset matches
//   low_offset : lowest matching offset (0 when none match)
module lvds_sync_search
  import lvds_pkg::*;
(
  input  logic [2*LVDS_WORD_W-2:0] window,
  input  logic [LVDS_WORD_W-1:0]   sync_word,
  output logic [LVDS_WORD_W-1:0]   match_vec,
  output logic                     any_match,
  output logic [LVDS_OFF_W-1:0]    low_offset
);

  // The top bit of the full 32-bit window can never start a candidate, so it is not passed in.
  always_comb begin
    match_vec = '0;
    for (int k = 0; k < LVDS_WORD_W; k++) begin
      match_vec[k] = (window[k +: LVDS_WORD_W] == sync_word);
    end
  end

  assign any_match = |match_vec;

  // Scan downwards so the lowest matching offset is the one left standing.
  always_comb begin
    low_offset = '0;
    for (int k = LVDS_WORD_W - 1; k >= 0; k--) begin
      if (match_vec[k]) low_offset = LVDS_OFF_W'(k);
    end
  end

endmodule

// File: rtl/lvds_frame_aligner.sv
// Bit/frame aligner for the 16-bit LVDS capture word stream.
// Hunts all bit offsets for the sync word, verifies framing over LOCK_CNT frames, then emits
// aligned payload words. UNLOCK_CNT consecutive sync misses drop back to hunting.
//   clk, rst     : word clock, asynchronous active-low reset
//   din          : raw captured word, one per clock
//   resync       : force a return to hunting
//   dout         : aligned payload word
//   dout_valid   : dout holds a payload word
//   dout_sof     : dout is payload word 1 of a frame
//   locked       : aligner is in the locked state
//   bit_offset   : bit offset in use
//   sync_err_cnt : saturating count of sync misses seen while locked
module lvds_frame_aligner
  import lvds_pkg::*;
#(
  parameter logic [LVDS_WORD_W-1:0] SYNC_WORD  = 16'hF628,
  parameter int unsigned            FRAME_LEN  = 8,
  parameter int unsigned            LOCK_CNT   = 3,
  parameter int unsigned            UNLOCK_CNT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LVDS_WORD_W-1:0] din,
  input  logic                   resync,
  output logic [LVDS_WORD_W-1:0] dout,
  output logic                   dout_valid,
  output logic                   dout_sof,
  output logic                   locked,
  output logic [LVDS_OFF_W-1:0]  bit_offset,
  output logic [15:0]            sync_err_cnt
);

  localparam int unsigned FcntW = $clog2(FRAME_LEN);
  localparam int unsigned HitW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = $clog2(UNLOCK_CNT + 1);

  lvds_state_e              state_q, state_d;
  logic [LVDS_WORD_W-1:0]   prev_q;
  logic [FcntW-1:0]         fcnt_q, fcnt_d, fcnt_inc;
  logic [HitW-1:0]          hits_q, hits_d;
  logic [MissW-1:0]         misses_q, misses_d;
  logic [LVDS_OFF_W-1:0]    offset_q, offset_d;
  logic [15:0]              err_q, err_d;
  logic [LVDS_WORD_W-1:0]   dout_q, dout_d;
  logic                     valid_q, valid_d, sof_q, sof_d, locked_q;

  logic [2*LVDS_WORD_W-2:0] window;
  logic [LVDS_WORD_W-1:0]   cand, match_vec;
  logic                     any_match, at_sync, sync_ok;
  logic [LVDS_OFF_W-1:0]    low_offset;

  assign window   = {din[LVDS_WORD_W-2:0], prev_q};
  assign cand     = window[offset_q +: LVDS_WORD_W];
  assign sync_ok  = match_vec[offset_q];
  // fcnt_inc is the frame position of the candidate being examined this cycle.
  assign fcnt_inc = (fcnt_q == FcntW'(FRAME_LEN - 1)) ? '0 : fcnt_q + 1'b1;
  assign at_sync  = (fcnt_inc == '0);

  lvds_sync_search u_search (
    .window     (window),
    .sync_word  (SYNC_WORD),
    .match_vec  (match_vec),
    .any_match  (any_match),
    .low_offset (low_offset)
  );

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    offset_d = offset_q;
    err_d    = err_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;

    if (resync) begin
      state_d  = StHunt;
      fcnt_d   = '0;
      hits_d   = '0;
      misses_d = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (any_match) begin
            offset_d = low_offset;
            fcnt_d   = '0;
            hits_d   = HitW'(1);
            misses_d = '0;
            state_d  = (LOCK_CNT <= 1) ? StLocked : StVerify;
          end
        end
        StVerify: begin
          fcnt_d = fcnt_inc;
          if (at_sync) begin
            if (sync_ok) begin
              hits_d = hits_q + 1'b1;
              if ((32'(hits_q) + 32'd1) >= LOCK_CNT) begin
                state_d  = StLocked;
                misses_d = '0;
              end
            end else begin
              state_d = StHunt;
              fcnt_d  = '0;
              hits_d  = '0;
            end
          end
        end
        StLocked: begin
          fcnt_d = fcnt_inc;
          if (!at_sync) begin
            dout_d  = cand;
            valid_d = 1'b1;
            sof_d   = (fcnt_inc == FcntW'(1));
          end else if (sync_ok) begin
            misses_d = '0;
          end else begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if ((32'(misses_q) + 32'd1) >= UNLOCK_CNT) begin
              state_d  = StHunt;
              fcnt_d   = '0;
              hits_d   = '0;
              misses_d = '0;
            end else begin
              // Keep offset and frame phase; a single bad sync is tolerated.
              misses_d = misses_q + 1'b1;
            end
          end
        end
        default: begin
          state_d  = StHunt;
          fcnt_d   = '0;
          hits_d   = '0;
          misses_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StHunt;
      prev_q   <= '0;
      fcnt_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      offset_q <= '0;
      err_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= din;
      fcnt_q   <= fcnt_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      offset_q <= offset_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      locked_q <= (state_d == StLocked);
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = valid_q;
  assign dout_sof     = sof_q;
  assign locked       = locked_q;
  assign bit_offset   = offset_q;
  assign sync_err_cnt = err_q;

endmodule
